wb_register_file: RTL and testbench
===================================

Name: wb_register_file

Overview:
- Architectural register file for the pipelined MIPS core; the consumer at the far end of the write-back interface.
- Accepts the WB stage's commit triple (RegWrite, WriteData, Dst) and writes it into 32 x 32-bit registers.
- Serves two combinational read ports to the ID stage.
- Keeps a committed-write counter for pipeline debug and benches.

Parameters:
- DATA_WIDTH, 32, register and data width in bits.
- ADDR_WIDTH, 5, register index width; depth is 2**ADDR_WIDTH.
- COUNT_WIDTH, 32, width of the committed-write counter.

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- WBRegWrite  input  1  write enable from the WB stage (its RegWriteOut).
- WBWriteReg  input  ADDR_WIDTH  destination register index (WB DstOut).
- WBWriteData  input  DATA_WIDTH  write-back data (WB WriteData).
- ReadReg1  input  ADDR_WIDTH  read port 1 index (rs).
- ReadReg2  input  ADDR_WIDTH  read port 2 index (rt).
- ReadData1  output  DATA_WIDTH  read port 1 data, combinational.
- ReadData2  output  DATA_WIDTH  read port 2 data, combinational.
- WriteCount  output  COUNT_WIDTH  number of committed non-$0 writes since reset.

Behaviour:
- Reset: reset_n low forces registers 1..31 to 0 and WriteCount to 0 immediately, without waiting for a clock edge.
  - While reset_n is low, ReadData1/ReadData2 read 0 for every index. With the bypass feature enabled, bypass is also suppressed during reset.
  - Reset takes priority over a write presented on the same edge; that write is lost.
  - Deassertion is asynchronous. The first rising edge with reset_n high can commit a write.
- Register 0 is hardwired to 0.
  - A write with WBWriteReg = 0 is discarded and does not increment WriteCount.
  - Reads of index 0 return 0 in all modes.
- Write: on a rising clock edge with WBRegWrite = 1 and WBWriteReg != 0:
  - reg[WBWriteReg] <= WBWriteData;
  - WriteCount <= WriteCount + 1.
  - Write latency is one edge. The stored value is visible to non-bypassed reads after that edge.
- WBRegWrite = 0: no state change. WBWriteReg and WBWriteData are don't-care.
- Read: ReadDataN = reg[ReadRegN], purely combinational from index to data with no clock latency.
- Both read ports may address the same register, including the write target. Each port resolves independently.
- WriteCount wraps modulo 2**COUNT_WIDTH: all-ones + 1 -> 0, with no flag or saturation.
- There is no X propagation from unwritten registers; every register is defined after reset.

Optional Feature:
- Macro: WB_REGFILE_BYPASS_EN.
- Defined: write-through bypass. When WBRegWrite = 1, WBWriteReg != 0 and WBWriteReg == ReadRegN, ReadDataN = WBWriteData in the same cycle, before the edge commits. This implements MIPS write-first-half/read-second-half semantics, so there is no WB->ID hazard.
- Not defined: ReadDataN always shows the stored value. A same-cycle WB->ID collision returns the old value, and the hazard unit must stall or forward.
- Write and counter behaviour are identical in both builds.

Test Plan:
- Reset: hold reset_n = 0 and read indices 0..31 -> all reads 0x00000000 and WriteCount = 0. Assert reset_n low mid-cycle after writing reg 13 -> reg 13 reads 0 immediately, with no clock edge needed.
- Basic write: WBRegWrite = 1, WBWriteReg = 5'b01101, WBWriteData = 0x12357968, one edge. Then ReadReg1 = 13 -> 0x12357968 and WriteCount = 1.
- Gated and $0 writes:
  - WBRegWrite = 0 with WBWriteReg = 13, data 0x76543210 -> reg 13 keeps 0x12357968.
  - WBRegWrite = 1, WBWriteReg = 0, data 0xFFFFFFFF -> reg 0 reads 0 and WriteCount is unchanged.
- Same-cycle collision: reg 7 = 0x11111111. Present write reg 7 = 0x22222222 with ReadReg1 = ReadReg2 = 7 before the edge:
  - bypass build -> both ports read 0x22222222;
  - non-bypass build -> both read 0x11111111, then 0x22222222 after the edge.
- Back-to-back: write regs 1..31 with data = index*0x01010101 on consecutive edges, then read all pairs -> every value matches and WriteCount = 31.
- Wrap: set COUNT_WIDTH = 4 and commit 17 writes -> WriteCount = 1.

Source files
------------

// File: rtl/wb_register_file.sv
// wb_register_file: architectural register file for the pipelined MIPS core.
// It takes the WB-stage commit triple (WBRegWrite, WBWriteReg, WBWriteData)
// and serves two combinational read ports to the ID stage. It also keeps a
// wrapping count of committed writes, which excludes writes to $0.
// Register 0 reads as zero in every mode. Writes to index 0 are discarded.
// Optional feature: define WB_REGFILE_BYPASS_EN to enable write-through bypass.
// In that build, a read of the register being committed in the same cycle
// returns the incoming data instead of the stored value.
module wb_register_file #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   WBRegWrite,
  input  logic [ADDR_WIDTH-1:0]  WBWriteReg,
  input  logic [DATA_WIDTH-1:0]  WBWriteData,
  input  logic [ADDR_WIDTH-1:0]  ReadReg1,
  input  logic [ADDR_WIDTH-1:0]  ReadReg2,
  output logic [DATA_WIDTH-1:0]  ReadData1,
  output logic [DATA_WIDTH-1:0]  ReadData2,
  output logic [COUNT_WIDTH-1:0] WriteCount
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regFile [DEPTH];
  logic                  commitWrite;
  logic                  bypassHit1;
  logic                  bypassHit2;

  // A write commits only when enabled and aimed at a real register.
  assign commitWrite = WBRegWrite && (WBWriteReg != '0);

`ifdef WB_REGFILE_BYPASS_EN
  assign bypassHit1 = commitWrite && (WBWriteReg == ReadReg1);
  assign bypassHit2 = commitWrite && (WBWriteReg == ReadReg2);
`else
  assign bypassHit1 = 1'b0;
  assign bypassHit2 = 1'b0;
`endif

  // Register storage: cleared asynchronously, written on the commit edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the array is built from flops, not RAM, so it can be reset.
      // Clearing every entry ensures that no read ever returns X.
      for (int i = 0; i < DEPTH; i++) begin
        // NOTE: sequential state uses <= so all flops update together.
        regFile[i] <= '0;
      end
    end else if (commitWrite) begin
      regFile[WBWriteReg] <= WBWriteData;
    end
  end

  // Committed-write counter; wraps naturally at its width.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      WriteCount <= '0;
    end else if (commitWrite) begin
      WriteCount <= WriteCount + COUNT_WIDTH'(1);
    end
  end

  // Read port 1: zero during reset and for $0; otherwise the bypass value or the stored value.
  always_comb begin
    // NOTE: the default is assigned first, so every path drives the output.
    // This prevents a latch from being inferred.
    ReadData1 = '0;
    if (reset_n && (ReadReg1 != '0)) begin
      ReadData1 = bypassHit1 ? WBWriteData : regFile[ReadReg1];
    end
  end

  // Read port 2: resolved independently of port 1.
  always_comb begin
    ReadData2 = '0;
    if (reset_n && (ReadReg2 != '0)) begin
      ReadData2 = bypassHit2 ? WBWriteData : regFile[ReadReg2];
    end
  end

endmodule

// File: tb/tb_wb_register_file.sv
// tb_wb_register_file: randomized self-checking bench for wb_register_file.
// The bench follows WB_REGFILE_BYPASS_EN in the same way as the design.
// A second instance, built with a 4-bit counter, exercises counter wrap.
module tb_wb_register_file;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        WBRegWrite;
  logic [4:0]  WBWriteReg;
  logic [31:0] WBWriteData;
  logic [4:0]  ReadReg1, ReadReg2;
  logic [31:0] ReadData1, ReadData2, WriteCount;
  logic [31:0] smallData1, smallData2;
  logic [3:0]  smallCount;

  // Reference state: the architectural register contents and the commit count.
  logic [31:0] refRegs [32];
  int unsigned refCount;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clock = ~clock;

  wb_register_file dut (
    .clock(clock), .reset_n(reset_n), .WBRegWrite(WBRegWrite),
    .WBWriteReg(WBWriteReg), .WBWriteData(WBWriteData),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .WriteCount(WriteCount)
  );

  wb_register_file #(.COUNT_WIDTH(4)) dutSmall (
    .clock(clock), .reset_n(reset_n), .WBRegWrite(WBRegWrite),
    .WBWriteReg(WBWriteReg), .WBWriteData(WBWriteData),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .ReadData1(smallData1), .ReadData2(smallData2), .WriteCount(smallCount)
  );

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Expected value at a read port, based on the architectural rules and the
  // inputs currently being driven.
  function automatic logic [31:0] expRead(input logic [4:0] idx);
    if (!reset_n || idx == 5'd0) return 32'h0;
`ifdef WB_REGFILE_BYPASS_EN
    if (WBRegWrite && WBWriteReg != 5'd0 && WBWriteReg == idx) return WBWriteData;
`endif
    return refRegs[idx];
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 32; i++) refRegs[i] = 32'h0;
    refCount = 0;
  endtask

  task automatic checkReads(input string tag);
    check({tag, ".rd1"}, ReadData1, expRead(ReadReg1));
    check({tag, ".rd2"}, ReadData2, expRead(ReadReg2));
    check({tag, ".cnt"}, WriteCount, refCount);
    check({tag, ".cnt4"}, {28'h0, smallCount}, refCount % 16);
  endtask

  // One bus cycle: drive at the falling edge, check before and after the rising edge.
  task automatic doCycle(input logic we, input logic [4:0] dst, input logic [31:0] data,
                         input logic [4:0] r1, input logic [4:0] r2, input string tag);
    @(negedge clock);
    WBRegWrite = we; WBWriteReg = dst; WBWriteData = data;
    ReadReg1 = r1; ReadReg2 = r2;
    #1;
    checkReads({tag, ".pre"});
    @(posedge clock);
    if (reset_n && we && dst != 5'd0) begin
      refRegs[dst] = data;
      refCount++;
    end
    #1;
    checkReads({tag, ".post"});
  endtask

  initial begin
    reset_n = 1'b0;
    WBRegWrite = 1'b0; WBWriteReg = '0; WBWriteData = '0;
    ReadReg1 = '0; ReadReg2 = '0;
    modelReset();

    // While reset is held, every index reads zero and a presented write is lost.
    for (int i = 0; i < 32; i++) begin
      ReadReg1 = 5'(i); ReadReg2 = 5'(31 - i);
      #1;
      check("rst.rd1", ReadData1, 32'h0);
      check("rst.rd2", ReadData2, 32'h0);
    end
    check("rst.cnt", WriteCount, 32'h0);
    doCycle(1'b1, 5'd9, 32'hDEAD_BEEF, 5'd9, 5'd9, "rstwrite");
    @(negedge clock);
    WBRegWrite = 1'b0;
    reset_n = 1'b1;

    // Basic write to register 13.
    doCycle(1'b1, 5'b01101, 32'h1235_7968, 5'd13, 5'd9, "basic");
    check("basic.val", ReadData1, 32'h1235_7968);
    check("basic.cnt1", WriteCount, 32'd1);

    // A gated write and a write to $0 change nothing.
    doCycle(1'b0, 5'd13, 32'h7654_3210, 5'd13, 5'd0, "gated");
    check("gated.keep", ReadData1, 32'h1235_7968);
    doCycle(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd13, "zero");
    check("zero.r0", ReadData1, 32'h0);
    check("zero.cnt", WriteCount, 32'd1);

    // Reset asserted mid-cycle clears register 13 with no clock edge needed.
    @(negedge clock);
    WBRegWrite = 1'b0; ReadReg1 = 5'd13;
    #1;
    reset_n = 1'b0;
    modelReset();
    #1;
    check("asyncrst.r13", ReadData1, 32'h0);
    check("asyncrst.cnt", WriteCount, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;

    // Same-cycle collision on register 7.
    doCycle(1'b1, 5'd7, 32'h1111_1111, 5'd7, 5'd7, "coll.setup");
    @(negedge clock);
    WBRegWrite = 1'b1; WBWriteReg = 5'd7; WBWriteData = 32'h2222_2222;
    ReadReg1 = 5'd7; ReadReg2 = 5'd7;
    #1;
`ifdef WB_REGFILE_BYPASS_EN
    check("coll.pre1", ReadData1, 32'h2222_2222);
    check("coll.pre2", ReadData2, 32'h2222_2222);
`else
    check("coll.pre1", ReadData1, 32'h1111_1111);
    check("coll.pre2", ReadData2, 32'h1111_1111);
`endif
    @(posedge clock);
    refRegs[7] = 32'h2222_2222; refCount++;
    #1;
    check("coll.post1", ReadData1, 32'h2222_2222);
    check("coll.post2", ReadData2, 32'h2222_2222);

    // Back-to-back writes to every register after a fresh reset, then read all pairs.
    @(negedge clock);
    WBRegWrite = 1'b0;
    reset_n = 1'b0;
    modelReset();
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 1; i < 32; i++)
      doCycle(1'b1, 5'(i), 32'(i) * 32'h0101_0101, 5'(i - 1), 5'(i), "b2b");
    @(negedge clock);
    WBRegWrite = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ReadReg1 = 5'(i); ReadReg2 = 5'(31 - i);
      #1;
      check("b2b.rd1", ReadData1, 32'(i) * 32'h0101_0101);
      check("b2b.rd2", ReadData2, 32'(31 - i) * 32'h0101_0101);
    end
    check("b2b.cnt31", WriteCount, 32'd31);

    // Counter wrap: 17 commits on a 4-bit counter leaves 1.
    @(negedge clock);
    reset_n = 1'b0;
    modelReset();
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 17; i++)
      doCycle(1'b1, 5'((i % 31) + 1), $urandom, 5'($urandom_range(0, 31)), 5'd0, "wrap");
    check("wrap.cnt4", {28'h0, smallCount}, 32'd1);
    check("wrap.cnt32", WriteCount, 32'd17);

    // Randomized traffic, with collisions between the write target and the read ports biased in.
    for (int n = 0; n < 400; n++) begin
      logic        we;
      logic [4:0]  dst, r1, r2;
      logic [31:0] data;
      we   = ($urandom_range(0, 3) != 0);
      dst  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      data = $urandom;
      r1   = ($urandom_range(0, 2) == 0) ? dst : 5'($urandom_range(0, 31));
      r2   = ($urandom_range(0, 2) == 0) ? dst : 5'($urandom_range(0, 31));
      doCycle(we, dst, data, r1, r2, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
